wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameters SHALL be: W, default 8, register data width; D, default 3, register index width; DEPTH, default 4, queue entries (power of two).
REQ-002 Ports SHALL be, in order:
  CLK          in   1      rising-edge clock
  RST_N        in   1      asynchronous active-low reset
  AluValid     in   1      ALU result offered
  AluReg       in   D      ALU destination register
  AluValue     in   W      ALU result
  AluReady     out  1      ALU result accepted this cycle
  MemValid     in   1      load result offered
  MemReg       in   D      load destination register
  MemValue     in   W      load data
  MemReady     out  1      load result accepted this cycle
  Stall        in   1      regfile write port unavailable; hold head
  WriteReg     out  1      regfile write enable
  WReg         out  D      regfile write index
  WriteValue   out  W      regfile write data
  LookupReg    in   D      forwarding query index
  LookupHit    out  1      pending write exists for LookupReg
  LookupValue  out  W      youngest pending value for LookupReg
  Count        out  clog2(DEPTH)+1  occupied entries
REQ-003 One clock domain, CLK; RST_N SHALL be asynchronous, active-low.

Function
REQ-004 Queue SHALL be a circular FIFO of {reg, value} entries with head/tail pointers one bit wider than the index for full/empty detection.
REQ-005 At most one enqueue per cycle; Mem has priority over ALU.
REQ-006 MemReady SHALL be Count<DEPTH; AluReady SHALL be Count<DEPTH and !MemValid; both combinational.
REQ-007 Enqueue occurs on a rising edge where Valid&&Ready for the selected source; entry written at tail, tail increments, wrapping at DEPTH.
REQ-008 WriteReg SHALL equal !empty && !Stall; WReg/WriteValue SHALL be the head entry combinationally (0 when empty).
REQ-009 Dequeue occurs on every edge where WriteReg=1; head increments with wrap.
REQ-010 Latency: an entry accepted at edge N into an empty, unstalled queue SHALL appear on WriteReg during cycle N+1 and retire at edge N+1.
REQ-011 Simultaneous enqueue and dequeue SHALL leave Count unchanged; enqueue while full SHALL be impossible (Ready=0), even if a dequeue occurs that cycle.
REQ-012 Count SHALL update on the same edge as enqueue/dequeue and never exceed DEPTH.
REQ-013 LookupHit SHALL be 1 iff any occupied entry holds LookupReg; LookupValue SHALL be the value of the youngest such entry (closest to tail), else 0; combinational, entries only (no bypass of same-cycle inputs).
REQ-014 Stall SHALL freeze head only; enqueue continues until full.
REQ-015 Duplicate destinations SHALL be retired in order, oldest first.

Reset
REQ-016 RST_N low SHALL immediately clear head, tail, Count to 0; outputs: WriteReg=0, WReg=0, WriteValue=0, LookupHit=0, LookupValue=0, AluReady=MemReady=1.
REQ-017 Reset mid-operation SHALL discard all pending entries; no regfile write occurs while RST_N is low.
REQ-018 Entry storage need not be reset; validity is derived solely from pointers.

Structure
REQ-019 Shared package wb_pkg SHALL hold the wb_entry_t struct {reg, value} and default W, D, DEPTH constants.
REQ-020 Single module; youngest-match search SHALL be a loop over occupied entries ordered from head; no sub-module.

Verification
REQ-021 Single ALU push R3=0x5A into empty queue, Stall=0 -> WriteReg=1, WReg=3, WriteValue=0x5A next cycle, Count back to 0 after.
REQ-022 AluValid and MemValid both high (ALU R1=0x11, Mem R2=0x22) -> MemReady=1, AluReady=0; R2 written first, ALU held and written after.
REQ-023 Stall=1, push 4 entries -> Count=4, both Ready=0; release Stall -> 4 writes in order, one per cycle, Ready returns next cycle.
REQ-024 Stall=1, push R5=0x01 then R5=0x02, LookupReg=5 -> LookupHit=1, LookupValue=0x02; LookupReg=6 -> LookupHit=0.
REQ-025 Pointer wrap: 10 push/drain pairs with Stall toggling -> all values retire in order, no loss or duplication.
REQ-026 Assert RST_N=0 with 3 entries queued -> WriteReg drops to 0 asynchronously, Count=0; after release no stale writes.

Source files
------------

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_pkg
// Brief  : Shared defaults and entry type for the write-back queue.
// Rev    : 1.0  initial release
// ============================================================================
package wb_pkg;

    localparam int WB_W     = 8;
    localparam int WB_D     = 3;
    localparam int WB_DEPTH = 4;

    // One pending register-file write at the default widths.
    typedef struct packed {
        logic [WB_D-1:0] rd;
        logic [WB_W-1:0] value;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
// Module : wb_queue
// Brief  : Write-back FIFO merging ALU and load results into one regfile port,
//          with youngest-match forwarding lookup.
// Rev    : 1.0  initial release
// ============================================================================
module wb_queue
    import wb_pkg::*;
#(
    parameter int W     = WB_W,
    parameter int D     = WB_D,
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     AluValid,
    input  logic [D-1:0]             AluReg,
    input  logic [W-1:0]             AluValue,
    output logic                     AluReady,
    input  logic                     MemValid,
    input  logic [D-1:0]             MemReg,
    input  logic [W-1:0]             MemValue,
    output logic                     MemReady,
    input  logic                     Stall,
    output logic                     WriteReg,
    output logic [D-1:0]             WReg,
    output logic [W-1:0]             WriteValue,
    input  logic [D-1:0]             LookupReg,
    output logic                     LookupHit,
    output logic [W-1:0]             LookupValue,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW:0]     C_DEPTH = (AW+1)'(DEPTH);

    logic [D-1:0]  r_reg_q [DEPTH];
    logic [W-1:0]  r_val_q [DEPTH];
    logic [AW:0]   r_head;
    logic [AW:0]   r_tail;

    logic [AW:0]   w_count;
    logic          w_empty;
    logic          w_full;
    logic          w_enq;
    logic          w_deq;
    logic [D-1:0]  w_enq_reg;
    logic [W-1:0]  w_enq_val;
    logic [AW-1:0] w_idx;

    assign w_count  = r_tail - r_head;
    assign w_empty  = (r_head == r_tail);
    assign w_full   = (w_count == C_DEPTH);

    assign MemReady = !w_full;
    assign AluReady = !w_full && !MemValid;
    assign Count    = w_count;

    // Loads win arbitration; the ALU simply sees Ready low that cycle.
    assign w_enq     = (MemValid && MemReady) || (AluValid && AluReady);
    assign w_enq_reg = MemValid ? MemReg   : AluReg;
    assign w_enq_val = MemValid ? MemValue : AluValue;

    assign w_deq      = !w_empty && !Stall;
    assign WriteReg   = w_deq;
    assign WReg       = w_empty ? '0 : r_reg_q[r_head[AW-1:0]];
    assign WriteValue = w_empty ? '0 : r_val_q[r_head[AW-1:0]];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + 1'b1;
            if (w_deq) r_head <= r_head + 1'b1;
        end
    end

    // Storage carries no reset; occupancy comes only from the pointers.
    always_ff @(posedge CLK) begin
        if (w_enq) begin
            r_reg_q[r_tail[AW-1:0]] <= w_enq_reg;
            r_val_q[r_tail[AW-1:0]] <= w_enq_val;
        end
    end

    // Walk from head toward tail so the last match seen is the youngest.
    always_comb begin
        LookupHit   = 1'b0;
        LookupValue = '0;
        w_idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head[AW-1:0] + AW'(i);
            if (((AW+1)'(i) < w_count) && (r_reg_q[w_idx] == LookupReg)) begin
                LookupHit   = 1'b1;
                LookupValue = r_val_q[w_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_queue
// Brief  : Randomised scoreboard bench for wb_queue against a queue model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_wb_queue;

    localparam int W = 8;
    localparam int D = 3;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b1;
    logic          AluValid = 1'b0, MemValid = 1'b0, Stall = 1'b0;
    logic [D-1:0]  AluReg = '0, MemReg = '0, LookupReg = '0;
    logic [W-1:0]  AluValue = '0, MemValue = '0;
    logic          AluReady, MemReady, WriteReg, LookupHit;
    logic [D-1:0]  WReg;
    logic [W-1:0]  WriteValue, LookupValue;
    logic [$clog2(DEPTH):0] Count;

    wb_queue #(.W(W), .D(D), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .AluValid(AluValid), .AluReg(AluReg), .AluValue(AluValue), .AluReady(AluReady),
        .MemValid(MemValid), .MemReg(MemReg), .MemValue(MemValue), .MemReady(MemReady),
        .Stall(Stall), .WriteReg(WriteReg), .WReg(WReg), .WriteValue(WriteValue),
        .LookupReg(LookupReg), .LookupHit(LookupHit), .LookupValue(LookupValue),
        .Count(Count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [D-1:0] r;
        logic [W-1:0] v;
    } ent_t;

    ent_t model[$];
    ent_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs, advance model.
    task automatic step(input logic av, input logic [D-1:0] ar, input logic [W-1:0] aval,
                        input logic mv, input logic [D-1:0] mr, input logic [W-1:0] mval,
                        input logic st, input logic [D-1:0] lk);
        bit           full;
        bit           hit;
        logic [W-1:0] hval;
        ent_t         e;
        @(negedge CLK);
        AluValid = av; AluReg = ar; AluValue = aval;
        MemValid = mv; MemReg = mr; MemValue = mval;
        Stall = st; LookupReg = lk;
        #1;
        full = (model.size() == DEPTH);
        hit  = 1'b0;
        hval = '0;
        for (int k = model.size() - 1; k >= 0; k--) begin
            if (!hit && model[k].r == lk) begin
                hit  = 1'b1;
                hval = model[k].v;
            end
        end
        chk("count", 32'(Count), 32'(model.size()));
        chk("mem_ready", 32'(MemReady), 32'(!full));
        chk("alu_ready", 32'(AluReady), 32'(!full && !mv));
        chk("write_reg", 32'(WriteReg), 32'(model.size() != 0 && !st));
        chk("lookup_hit", 32'(LookupHit), 32'(hit));
        chk("lookup_value", 32'(LookupValue), 32'(hval));
        if (model.size() != 0 && !st) void'(model.pop_front());
        if (!full && (mv || av)) begin
            e.r = mv ? mr : ar;
            e.v = mv ? mval : aval;
            model.push_back(e);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input logic st);
        step(1'b0, '0, '0, 1'b0, '0, '0, st, '0);
    endtask

    // Monitor: every retiring write must match the oldest expected entry.
    initial begin
        ent_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (WriteReg === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(WReg), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wreg", 32'(WReg), 32'(e.r));
                    chk("write_value", 32'(WriteValue), 32'(e.v));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        #1 RST_N = 1'b0;
        #2;
        chk("rst_write_reg", 32'(WriteReg), 32'd0);
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_mem_ready", 32'(MemReady), 32'd1);
        chk("rst_alu_ready", 32'(AluReady), 32'd1);
        chk("rst_wreg", 32'(WReg), 32'd0);
        chk("rst_write_value", 32'(WriteValue), 32'd0);
        chk("rst_lookup_hit", 32'(LookupHit), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Single ALU push into an empty queue.
        step(1'b1, 3'd3, 8'h5A, 1'b0, '0, '0, 1'b0, 3'd3);
        idle(1'b0);
        idle(1'b0);

        // Both sources offered: load wins, ALU retries.
        step(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0, '0);
        step(1'b1, 3'd1, 8'h11, 1'b0, '0, '0, 1'b0, '0);
        idle(1'b0);
        idle(1'b0);

        // Fill while stalled, try to overfill, then drain.
        for (int k = 0; k < DEPTH; k++)
            step(1'b1, 3'(k + 4), 8'(8'hA0 + k), 1'b0, '0, '0, 1'b1, 3'd5);
        step(1'b1, 3'd7, 8'hEE, 1'b1, 3'd6, 8'hDD, 1'b1, 3'd6);
        for (int k = 0; k < DEPTH + 2; k++) idle(1'b0);

        // Duplicate destinations: lookup returns the youngest.
        step(1'b1, 3'd5, 8'h01, 1'b0, '0, '0, 1'b1, 3'd5);
        step(1'b1, 3'd5, 8'h02, 1'b0, '0, '0, 1'b1, 3'd5);
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 3'd5);
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 3'd6);
        for (int k = 0; k < 3; k++) idle(1'b0);

        // Push/drain pairs with stall toggling to exercise pointer wrap.
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 3'(k), 8'(8'h30 + k), 1'b0, '0, '0, 1'(k % 2), 3'(k));
            idle(1'b0);
        end

        // Random traffic.
        for (int k = 0; k < 400; k++)
            step(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom),
                 1'($urandom_range(0, 2) == 0), 3'($urandom), 8'($urandom),
                 1'($urandom_range(0, 2) == 0), 3'($urandom));
        for (int k = 0; k < 10; k++) idle(1'b0);

        // Reset with three entries pending.
        for (int k = 0; k < 3; k++)
            step(1'b1, 3'(k + 1), 8'(8'hC0 + k), 1'b0, '0, '0, 1'b1, '0);
        @(negedge CLK);
        Stall = 1'b0;
        AluValid = 1'b0;
        #3 RST_N = 1'b0;
        #1;
        chk("midrst_write_reg", 32'(WriteReg), 32'd0);
        chk("midrst_count", 32'(Count), 32'd0);
        chk("midrst_alu_ready", 32'(AluReady), 32'd1);
        model.delete();
        exp_q.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < 4; k++) idle(1'b0);
        step(1'b1, 3'd2, 8'h77, 1'b0, '0, '0, 1'b0, 3'd2);
        for (int k = 0; k < 3; k++) idle(1'b0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
